// File: rtl/vec3_normalize_if.sv
// Handshake and LUT-side signal bundle for vec3_normalize.
// slave = the normaliser's view, master = producer/consumer/LUT side.
interface vec3_normalize_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_LENGTH = 12
);
    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_WIDTH-1:0]  in_x;
    logic [DATA_WIDTH-1:0]  in_y;
    logic [DATA_WIDTH-1:0]  in_z;

    logic [ADDR_LENGTH-1:0] lut_addr;
    logic                   lut_en;
    logic [DATA_WIDTH-1:0]  lut_data;
    logic                   lut_valid;

    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_WIDTH-1:0]  out_x;
    logic [DATA_WIDTH-1:0]  out_y;
    logic [DATA_WIDTH-1:0]  out_z;

    modport slave (
        input  in_valid, in_x, in_y, in_z, lut_data, lut_valid, out_ready,
        output in_ready, lut_addr, lut_en, out_valid, out_x, out_y, out_z
    );

    modport master (
        output in_valid, in_x, in_y, in_z, lut_data, lut_valid, out_ready,
        input  in_ready, lut_addr, lut_en, out_valid, out_x, out_y, out_z
    );
endinterface

// File: rtl/vec3_normalize.sv
// Normalises a signed fixed-point 3-vector via an external 1/sqrt LUT (NORM_ADDR_SATURATE_EN clamps the LUT index).
// Latency: 5 cycles accept-to-out_valid with a 1-cycle LUT, +1 per extra LUT cycle; one vector in flight.
// Backpressure: in_ready only in IDLE; out_valid and data hold in DONE until out_ready.
module vec3_normalize #(
    parameter int DATA_WIDTH  = 32,
    parameter int FRAC_BITS   = 16,
    parameter int ADDR_LENGTH = 12,
    parameter int ADDR_SHIFT  = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    vec3_normalize_if.slave   bus
);
    localparam int PW = 2 * DATA_WIDTH;
    localparam int SW = PW + 2;

    typedef enum logic [2:0] {
        IDLE, SQ, SUM, LUT, WAIT, SCALE, DONE
    } state_t;

    state_t state, state_nxt;

    logic signed [DATA_WIDTH-1:0] x_q, y_q, z_q;
    logic signed [PW-1:0]         sq_x, sq_y, sq_z;
    logic [DATA_WIDTH-1:0]        inv_q;
    logic [ADDR_LENGTH-1:0]       addr_q, addr_nxt;
    logic [DATA_WIDTH-1:0]        ox_q, oy_q, oz_q;
    logic [SW-1:0]                sum_sq, idx;

    // Component times zero-extended inverse, floored by the arithmetic shift.
    function automatic logic [DATA_WIDTH-1:0] scale(input logic signed [DATA_WIDTH-1:0] c,
                                                    input logic [DATA_WIDTH-1:0] inv);
        logic signed [PW:0] p;
        p = (PW+1)'(c) * (PW+1)'($signed({1'b0, inv}));
        return DATA_WIDTH'(p >>> FRAC_BITS);
    endfunction

    always_comb begin
        sum_sq = {2'b00, sq_x} + {2'b00, sq_y} + {2'b00, sq_z};
        idx    = sum_sq >> (FRAC_BITS + ADDR_SHIFT);
`ifdef NORM_ADDR_SATURATE_EN
        if ((idx >> ADDR_LENGTH) != '0) addr_nxt = '1;
        else                            addr_nxt = ADDR_LENGTH'(idx);
`else
        addr_nxt = ADDR_LENGTH'(idx);
`endif
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.in_valid)  state_nxt = SQ;
            SQ:                         state_nxt = SUM;
            SUM:                        state_nxt = LUT;
            LUT:                        state_nxt = WAIT;
            WAIT:    if (bus.lut_valid) state_nxt = SCALE;
            SCALE:                      state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
            sq_x   <= '0;
            sq_y   <= '0;
            sq_z   <= '0;
            inv_q  <= '0;
            addr_q <= '0;
            ox_q   <= '0;
            oy_q   <= '0;
            oz_q   <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    x_q <= $signed(bus.in_x);
                    y_q <= $signed(bus.in_y);
                    z_q <= $signed(bus.in_z);
                end
                SQ: begin
                    sq_x <= PW'(x_q) * PW'(x_q);
                    sq_y <= PW'(y_q) * PW'(y_q);
                    sq_z <= PW'(z_q) * PW'(z_q);
                end
                SUM:  addr_q <= addr_nxt;
                WAIT: if (bus.lut_valid) inv_q <= bus.lut_data;
                SCALE: begin
                    ox_q <= scale(x_q, inv_q);
                    oy_q <= scale(y_q, inv_q);
                    oz_q <= scale(z_q, inv_q);
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.lut_en    = (state == LUT);
    assign bus.lut_addr  = addr_q;
    assign bus.out_valid = (state == DONE);
    assign bus.out_x     = ox_q;
    assign bus.out_y     = oy_q;
    assign bus.out_z     = oz_q;
endmodule

// File: tb/tb_vec3_normalize.sv
// Scoreboard bench for vec3_normalize: directed vectors, LUT model with adjustable latency.
module tb_vec3_normalize;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vec3_normalize_if bus ();
    vec3_normalize dut (.clk(clk), .rst_n(rst_n), .bus(bus));

`ifdef NORM_ADDR_SATURATE_EN
    localparam logic [11:0] RANGE_ADDR = 12'hFFF;
`else
    localparam logic [11:0] RANGE_ADDR = 12'h000;
`endif

    typedef struct {
        logic [31:0] x, y, z;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        exp_q[$];
    logic [11:0] addr_q[$];
    exp_t        cur;
    logic [11:0] a_exp;
    logic        prev_ov = 1'b0;

    int npass = 0;
    int ntotal = 0;
    int cyc = 0;

    // LUT model: lut_valid is lut_en delayed by lut_delay cycles; not reset, so late pulses survive a DUT reset.
    int         lut_delay = 1;
    logic       spur = 1'b0;
    logic [7:0] lut_sr = '0;
    always @(posedge clk) begin
        cyc    <= cyc + 1;
        lut_sr <= {lut_sr[6:0], bus.lut_en};
    end
    assign bus.lut_valid = lut_sr[lut_delay-1] | spur;
    assign bus.lut_data  = 32'h0000_3333;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        ntotal++;
        if (act === expv) npass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    endtask

    task automatic fail_now(input string name);
        ntotal++;
        $display("FAIL %s", name);
    endtask

    // Monitor: LUT address on each lut_en pulse, latency on out_valid rise, data on handshake.
    always @(negedge clk) begin
        if (bus.lut_en) begin
            if (addr_q.size() == 0) fail_now("lut_en with no vector pending");
            else begin
                a_exp = addr_q.pop_front();
                check("lut_addr", bus.lut_addr, a_exp);
            end
        end
        if (bus.out_valid && !prev_ov) begin
            if (exp_q.size() == 0) fail_now("out_valid with empty scoreboard");
            else begin
                cur = exp_q.pop_front();
                check("latency", cyc - cur.acc, cur.lat);
            end
        end
        if (bus.out_valid && bus.out_ready) begin
            check("out_x", bus.out_x, cur.x);
            check("out_y", bus.out_y, cur.y);
            check("out_z", bus.out_z, cur.z);
        end
        prev_ov = bus.out_valid;
    end

    task automatic send(input logic [31:0] x, y, z, input logic [11:0] a,
                        input logic [31:0] ex, ey, ez, input int lat, input bit score);
        int   n;
        exp_t e;
        bus.in_x     = x;
        bus.in_y     = y;
        bus.in_z     = z;
        bus.in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            fail_now("accept timeout");
            bus.in_valid = 1'b0;
            return;
        end
        addr_q.push_back(a);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (score) begin
            e.x = ex; e.y = ey; e.z = ez; e.lat = lat; e.acc = cyc;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail_now("drain timeout");
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.in_y      = '0;
        bus.in_z      = '0;
        bus.out_ready = 1'b1;

        #2;
        check("rst lut_en", bus.lut_en, 0);
        check("rst lut_addr", bus.lut_addr, 0);
        check("rst out_valid", bus.out_valid, 0);
        check("rst out_x", bus.out_x, 0);
        check("rst out_y", bus.out_y, 0);
        check("rst out_z", bus.out_z, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("in_ready after reset", bus.in_ready, 1);
        @(posedge clk);
        #1;

        // Directed table: (x, y, z) -> LUT address, expected outputs
        send(32'h0003_0000, 32'h0004_0000, 32'h0, 12'h190,
             32'h0000_9999, 32'h0000_CCCC, 32'h0, 5, 1);
        drain();
        send(32'hFFFD_0000, 32'h0004_0000, 32'h0, 12'h190,
             32'hFFFF_6667, 32'h0000_CCCC, 32'h0, 5, 1);
        drain();
        send(32'h0000_8000, 32'hFFFF_8000, 32'h0000_8000, 12'h00C,
             32'h0000_1999, 32'hFFFF_E666, 32'h0000_1999, 5, 1);
        drain();
        send(32'h0, 32'h0, 32'h0, 12'h000, 32'h0, 32'h0, 32'h0, 5, 1);
        drain();
        send(32'h0020_0000, 32'h0, 32'h0, RANGE_ADDR,
             32'h0006_6660, 32'h0, 32'h0, 5, 1);
        drain();

        // Backpressure: hold out_ready low for 10 cycles of out_valid
        bus.out_ready = 1'b0;
        send(32'h0003_0000, 32'h0004_0000, 32'h0, 12'h190,
             32'h0000_9999, 32'h0000_CCCC, 32'h0, 5, 1);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.out_valid) fail_now("bp out_valid timeout");
        for (int i = 0; i < 10; i++) begin
            check("bp out_valid", bus.out_valid, 1);
            check("bp in_ready", bus.in_ready, 0);
            check("bp out_x", bus.out_x, 32'h0000_9999);
            check("bp out_y", bus.out_y, 32'h0000_CCCC);
            @(negedge clk);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("in_ready after handshake", bus.in_ready, 1);
        @(posedge clk);
        #1;
        send(32'hFFFD_0000, 32'h0004_0000, 32'h0, 12'h190,
             32'hFFFF_6667, 32'h0000_CCCC, 32'h0, 5, 1);
        drain();

        // Slow LUT with a spurious lut_valid during SQ
        lut_delay = 3;
        send(32'h0003_0000, 32'h0004_0000, 32'h0, 12'h190,
             32'h0000_9999, 32'h0000_CCCC, 32'h0, 7, 1);
        spur = 1'b1;
        @(posedge clk);
        #1 spur = 1'b0;
        drain();

        // Reset while waiting on the slow LUT
        send(32'h0, 32'h0, 32'h0005_0000, 12'h190, 32'h0, 32'h0, 32'h0, 0, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst out_valid", bus.out_valid, 0);
        check("midrst out_x", bus.out_x, 0);
        check("midrst out_y", bus.out_y, 0);
        check("midrst lut_en", bus.lut_en, 0);
        check("midrst lut_addr", bus.lut_addr, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post-rst out_valid", bus.out_valid, 0);
            check("post-rst in_ready", bus.in_ready, 1);
        end
        @(posedge clk);
        #1 lut_delay = 1;

        send(32'h0000_8000, 32'hFFFF_8000, 32'h0000_8000, 12'h00C,
             32'h0000_1999, 32'hFFFF_E666, 32'h0000_1999, 5, 1);
        drain();

        check("scoreboard empty", exp_q.size(), 0);
        check("addr queue empty", addr_q.size(), 0);
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
